// File: rtl/led_seq_ctrl_pkg.sv
// Shared codes for the LED sequencer: FSM states, rate steps, direction and
// the bit layout of the tick-counter configuration word.
package led_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN_LEFT  = 2'd1,
        ST_RUN_RIGHT = 2'd2,
        ST_PAUSE     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RATE_0 = 2'b00,
        RATE_1 = 2'b01,
        RATE_2 = 2'b10,
        RATE_3 = 2'b11
    } rate_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int unsigned SW_EN_BIT   = 0;
    localparam int unsigned SW_RATE_LSB = 1;
    localparam int unsigned SW_RATE_MSB = 2;

    function automatic logic is_run(input state_e s);
        return (s == ST_RUN_LEFT) || (s == ST_RUN_RIGHT);
    endfunction

endpackage

// File: rtl/led_seq_ctrl_btn_edge.sv
// Button conditioner: 2-flop synchronizer, then a registered one-cycle pulse
// on each rising edge of the synchronized level.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic loaded_q, loaded_d;
    logic seen_low_q, seen_low_d;
    logic pulse_q, pulse_d;

    // seen_low only arms after a genuine low sample, so a button held
    // through reset cannot fake a rising edge against the reset zeros.
    always_comb begin
        sync1_d    = i_btn;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        loaded_d   = 1'b1;
        seen_low_d = seen_low_q | (loaded_q & ~sync1_q);
        pulse_d    = sync2_q & ~prev_q & seen_low_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            loaded_q   <= 1'b0;
            seen_low_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            loaded_q   <= loaded_d;
            seen_low_q <= seen_low_d;
            pulse_q    <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: start/pause, direction and rate buttons drive a rotating
// one-hot pattern that advances on each rising edge of the tick counter's valid.
module led_seq_ctrl
    import led_seq_ctrl_pkg::*;
#(
    parameter int NB_LEDS = 4,
    parameter int NB_SW   = 3
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_btn_start,
    input  logic               i_btn_dir,
    input  logic               i_btn_speed,
    input  logic               i_valid,
    output logic [NB_SW-1:0]   o_sw,
    output logic [NB_LEDS-1:0] o_led,
    output logic [1:0]         o_state
);

    logic start_p, dir_p, speed_p, step;

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    rate_e              rate_q, rate_d;
    logic [NB_LEDS-1:0] led_q, led_d;
    logic [NB_SW-1:0]   sw_q, sw_d;
    logic               valid_prev_q, valid_prev_d;

    btn_edge u_btn_start (.clk(clock), .rst_n(i_reset), .i_btn(i_btn_start), .o_pulse(start_p));
    btn_edge u_btn_dir   (.clk(clock), .rst_n(i_reset), .i_btn(i_btn_dir),   .o_pulse(dir_p));
    btn_edge u_btn_speed (.clk(clock), .rst_n(i_reset), .i_btn(i_btn_speed), .o_pulse(speed_p));

    assign step = i_valid & ~valid_prev_q;

    // Rotation uses the current state's direction; a coincident start or dir
    // pulse only changes the state that the next step will see.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        rate_d       = rate_q;
        led_d        = led_q;
        valid_prev_d = i_valid;

        if (speed_p) rate_d = rate_e'(rate_q + 2'd1);

        case (state_q)
            ST_IDLE: begin
                led_d = '0;
                if (start_p) begin
                    state_d  = ST_RUN_LEFT;
                    led_d[0] = 1'b1;
                end
            end
            ST_RUN_LEFT: begin
                if (step) led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
                if (start_p) begin
                    dir_d   = DIR_LEFT;
                    state_d = ST_PAUSE;
                end else if (dir_p) begin
                    state_d = ST_RUN_RIGHT;
                end
            end
            ST_RUN_RIGHT: begin
                if (step) led_d = {led_q[0], led_q[NB_LEDS-1:1]};
                if (start_p) begin
                    dir_d   = DIR_RIGHT;
                    state_d = ST_PAUSE;
                end else if (dir_p) begin
                    state_d = ST_RUN_LEFT;
                end
            end
            ST_PAUSE: begin
                if (start_p) begin
                    state_d = (dir_q == DIR_LEFT) ? ST_RUN_LEFT : ST_RUN_RIGHT;
                end else if (dir_p) begin
                    dir_d = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = '0;
            end
        endcase

        sw_d                          = '0;
        sw_d[SW_EN_BIT]               = is_run(state_d);
        sw_d[SW_RATE_MSB:SW_RATE_LSB] = rate_d;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_LEFT;
            rate_q       <= RATE_0;
            led_q        <= '0;
            sw_q         <= '0;
            valid_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            rate_q       <= rate_d;
            led_q        <= led_d;
            sw_q         <= sw_d;
            valid_prev_q <= valid_prev_d;
        end
    end

    assign o_sw    = sw_q;
    assign o_led   = led_q;
    assign o_state = state_q;

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 The module SHALL have parameter NB_LEDS, default 4, the LED vector width (minimum 2).
REQ-002 The module SHALL have parameter NB_SW, default 3, the counter configuration width (bit 0 enable, bits 2:1 rate select).
REQ-003 The module SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port i_reset, input, 1, an asynchronous, active-low reset.
REQ-005 The module SHALL have port i_btn_start, input, 1, the asynchronous start/pause button, active-high.
REQ-006 The module SHALL have port i_btn_dir, input, 1, the asynchronous direction-toggle button, active-high.
REQ-007 The module SHALL have port i_btn_speed, input, 1, the asynchronous rate-step button, active-high.
REQ-008 The module SHALL have port i_valid, input, 1, the tick-counter valid flag, synchronous to clock and level-held by the counter.
REQ-009 The module SHALL have port o_sw, output, NB_SW, the configuration driven into the tick counter's switch input.
REQ-010 The module SHALL have port o_led, output, NB_LEDS, the LED pattern.
REQ-011 The module SHALL have port o_state, output, 2, the current FSM state code.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer and rising-edge detect, producing a one-cycle pulse; a held button SHALL produce exactly one pulse.
REQ-013 Button latency SHALL be fixed: a level sampled high at edge N produces a pulse in cycle N+2, and state/output updates at edge N+3.
REQ-014 A step SHALL be the rising edge of i_valid (high now, low in the previous cycle), with no synchronizer.
REQ-015 A level-held i_valid SHALL never produce a second step.
REQ-016 The FSM SHALL have states IDLE=0, RUN_LEFT=1, RUN_RIGHT=2, PAUSE=3.
REQ-017 On a start pulse, IDLE SHALL go to RUN_LEFT with o_led set to one-hot bit 0.
REQ-018 On a start pulse, RUN_LEFT and RUN_RIGHT SHALL go to PAUSE, recording the direction.
REQ-019 On a start pulse, PAUSE SHALL return to the recorded direction's RUN state.
REQ-020 On a dir pulse, RUN_LEFT and RUN_RIGHT SHALL swap with each other.
REQ-021 On a dir pulse, PAUSE SHALL toggle the recorded direction and stay in PAUSE.
REQ-022 In IDLE, a dir pulse SHALL be ignored.
REQ-023 When start and dir pulses coincide, start SHALL win and dir SHALL be discarded.
REQ-024 A speed pulse SHALL step the rate 00->01->10->11->00 (wrap) in any state, independent of other pulses.
REQ-025 On a step in RUN_LEFT, o_led SHALL rotate left (MSB wraps to bit 0).
REQ-026 On a step in RUN_RIGHT, o_led SHALL rotate right (bit 0 wraps to MSB).
REQ-027 In IDLE and PAUSE, steps SHALL be ignored.
REQ-028 When a step and a dir pulse coincide, the rotation SHALL use the pre-toggle direction and the new direction SHALL apply from the next step.
REQ-029 When a step and a start (pause) pulse coincide, the rotation SHALL occur and then the FSM SHALL pause.
REQ-030 o_sw[0] SHALL be 1 only in RUN_LEFT or RUN_RIGHT.
REQ-031 o_sw[2:1] SHALL equal the rate register at all times.
REQ-032 All outputs SHALL be registered.
REQ-033 o_led SHALL always be one-hot outside IDLE.
REQ-034 o_led SHALL be zero in IDLE.

Reset
REQ-035 Asserting i_reset low SHALL immediately clear state to IDLE, o_led to 0, o_sw to 0, rate to 00, recorded direction to left, and all synchronizer and edge flops to 0.
REQ-036 After deassertion, the first state change SHALL require a fresh button rising edge; a button held through reset SHALL not pulse.
REQ-037 Reset mid-RUN SHALL discard the pattern, and the next start SHALL restart from one-hot bit 0.

Structure
REQ-038 State codes, rate codes and the o_sw bit positions SHALL live in the shared project package/header.
REQ-039 A sub-module btn_edge (2-flop synchronizer plus rising-edge pulse, asynchronous active-low reset) SHALL be instantiated once per button.
REQ-040 The i_valid edge detect SHALL be inline.
REQ-041 The tick counter SHALL not be instantiated inside this block; the top level SHALL connect o_sw to it and its valid output to i_valid.

Verification
REQ-042 Reset then start pulse, then 5 i_valid rising edges: o_state=1, o_sw=3'b001, o_led 0001->0010->0100->1000->0001->0010.
REQ-043 Start held high for 20 cycles: exactly one transition, IDLE->RUN_LEFT, with o_state=1 on the third edge after first sample.
REQ-044 i_valid held high for 50 cycles in RUN_LEFT: o_led advances exactly once.
REQ-045 Dir pulse coinciding with a step at o_led=0100 in RUN_LEFT: o_led=1000 and o_state=2; next step gives o_led=0100.
REQ-046 Four speed pulses from reset: o_sw[2:1]=01,10,11,00; start and dir pulses together in RUN_RIGHT give PAUSE with o_sw[0]=0.
REQ-047 i_reset low asynchronously mid-cycle in RUN_RIGHT: all outputs 0 before the next clock edge.
